// File: rtl/risc32_pipe_ctrl_if.sv
// Hazard-controller bus: stall/flush/exception requests in, per-stage controls out.
// master = pipeline side issuing requests, slave = the controller.
interface risc32_pipe_ctrl_if #(
    parameter int unsigned STAGES = 6,
    parameter int unsigned NREQ   = 2,
    parameter int unsigned LVL_W  = 3
);
    logic [NREQ-1:0]   stall_req;
    logic              flush_req;
    logic [LVL_W-1:0]  flush_lvl;
    logic              excp_req;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic              flush_ok;
    logic              excp_busy;
    logic              excp_ack;
    logic              wdog_err;

    modport master (
        output stall_req, flush_req, flush_lvl, excp_req,
        input  stall, flush, flush_ok, excp_busy, excp_ack, wdog_err
    );

    modport slave (
        input  stall_req, flush_req, flush_lvl, excp_req,
        output stall, flush, flush_ok, excp_busy, excp_ack, wdog_err
    );
endinterface

// File: rtl/risc32_pipe_ctrl.sv
// Pipeline hazard controller: stall merge, branch flush, exception flush/drain.
// Optional stall watchdog enabled by defining RISC32_CTRL_WDOG_EN.
module risc32_pipe_ctrl #(
    parameter int unsigned STAGES    = 6,
    parameter int unsigned NREQ      = 2,
    parameter int unsigned LVL_W     = 3,
    parameter logic [NREQ*LVL_W-1:0] REQ_LVL = {3'd3, 3'd2},
    parameter int unsigned DRAIN_CYC = 2,
    parameter int unsigned WDOG_MAX  = 255
) (
    input logic              clk,
    input logic              rst,
    risc32_pipe_ctrl_if.slave bus
);

    if (STAGES < 3 || (2 ** LVL_W) < STAGES) begin : g_bad_geom
        $error("risc32_pipe_ctrl: bad STAGES/LVL_W");
    end
    if (DRAIN_CYC < 1 || DRAIN_CYC > 255) begin : g_bad_drain
        $error("risc32_pipe_ctrl: DRAIN_CYC out of range");
    end
    if (WDOG_MAX < 1 || WDOG_MAX > 65535) begin : g_bad_wdog
        $error("risc32_pipe_ctrl: WDOG_MAX out of range");
    end

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    // WB is never held by a requester, so levels clamp one below it
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(STAGES - 2);

    state_t            state_q, state_d;
    logic [7:0]        drain_cnt_q, drain_cnt_d;
    logic              ack_q, ack_d;
    logic [LVL_W-1:0]  lvl;
    logic              nostall;
    logic [STAGES-1:0] stall_c;
    logic [STAGES-1:0] flush_c;
    logic              flush_ok_c;
    logic              wdog_err_c;

    always_comb begin
        logic [LVL_W-1:0] rl;
        lvl     = '0;
        nostall = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            rl = REQ_LVL[i*LVL_W +: LVL_W];
            if (rl > LVL_MAX) rl = LVL_MAX;
            if (bus.stall_req[i]) begin
                nostall = 1'b0;
                if (rl > lvl) lvl = rl;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        ack_d       = 1'b0;
        stall_c     = '0;
        flush_c     = '0;
        flush_ok_c  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (!nostall) begin
                    for (int j = 0; j < STAGES; j++)
                        stall_c[j] = (j <= int'(lvl));
                end
                if (bus.flush_req && (nostall || lvl < bus.flush_lvl)) begin
                    stall_c    = '0;
                    flush_ok_c = 1'b1;
                    for (int j = 1; j < STAGES; j++)
                        flush_c[j] = (j < int'(bus.flush_lvl));
                end
                if (bus.excp_req) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_c     = '1;
                drain_cnt_d = 8'(DRAIN_CYC);
                state_d     = ST_DRAIN;
            end
            ST_DRAIN: begin
                stall_c[0]  = 1'b1;
                drain_cnt_d = drain_cnt_q - 8'd1;
                if (drain_cnt_q == 8'd1) begin
                    state_d = ST_RUN;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            ack_q       <= ack_d;
        end
    end

`ifdef RISC32_CTRL_WDOG_EN
    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_err_q, wdog_err_d;

    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        wdog_err_d = wdog_err_q;
        if (state_q == ST_RUN) begin
            if (stall_c[0]) begin
                if (wdog_cnt_q < 16'(WDOG_MAX))
                    wdog_cnt_d = wdog_cnt_q + 16'd1;
                if (wdog_cnt_d == 16'(WDOG_MAX))
                    wdog_err_d = 1'b1;
            end else begin
                wdog_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err_c = wdog_err_q;
`else
    assign wdog_err_c = 1'b0;
`endif

    assign bus.stall     = rst ? '0 : stall_c;
    assign bus.flush     = rst ? '0 : flush_c;
    assign bus.flush_ok  = !rst && flush_ok_c;
    assign bus.excp_busy = !rst && (state_q != ST_RUN);
    assign bus.excp_ack  = !rst && ack_q;
    assign bus.wdog_err  = !rst && wdog_err_c;

endmodule

// File: tb/tb_risc32_pipe_ctrl.sv
// Directed bench for risc32_pipe_ctrl with an expected-output scoreboard.
// Watchdog expectations follow RISC32_CTRL_WDOG_EN (WDOG_MAX = 4).
module tb_risc32_pipe_ctrl;

    typedef struct packed {
        logic [5:0] stall;
        logic [5:0] flush;
        logic       fok;
        logic       busy;
        logic       ack;
        logic       wdog;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   wd_cnt  = 0;
    logic wd_err  = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    risc32_pipe_ctrl_if #(.STAGES(6), .NREQ(2), .LVL_W(3)) bus ();

    risc32_pipe_ctrl #(.WDOG_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step(
        input string      tag,
        input logic       r,
        input logic [1:0] sr,
        input logic       fr,
        input logic [2:0] fl,
        input logic       er,
        input logic [5:0] es,
        input logic [5:0] ef,
        input logic       eok,
        input logic       eb,
        input logic       ea
    );
        exp_t e;
        exp_t obs;
        rst           = r;
        bus.stall_req = sr;
        bus.flush_req = fr;
        bus.flush_lvl = fl;
        bus.excp_req  = er;
        e = '{stall: es, flush: ef, fok: eok, busy: eb, ack: ea,
              wdog: (r ? 1'b0 : wd_err)};
        sb.push_back(e);
        @(negedge clk);
        obs = '{stall: bus.stall, flush: bus.flush, fok: bus.flush_ok,
                busy: bus.excp_busy, ack: bus.excp_ack, wdog: bus.wdog_err};
        e = sb.pop_front();
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
        if (r) begin
            wd_cnt = 0;
            wd_err = 1'b0;
        end else if (!eb) begin
            if (es[0]) begin
                if (wd_cnt < 4) wd_cnt++;
`ifdef RISC32_CTRL_WDOG_EN
                if (wd_cnt == 4) wd_err = 1'b1;
`endif
            end else begin
                wd_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset gates every output even with all requests active
        step("rst0", 1, 2'b11, 1, 3'd3, 1, 6'h00, 6'h00, 0, 0, 0);
        step("rst1", 1, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 0);

        step("stall01", 0, 2'b01, 0, 3'd0, 0, 6'h07, 6'h00, 0, 0, 0);
        step("stall11", 0, 2'b11, 0, 3'd0, 0, 6'h0f, 6'h00, 0, 0, 0);
        step("stall10", 0, 2'b10, 0, 3'd0, 0, 6'h0f, 6'h00, 0, 0, 0);
        step("idle0",   0, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 0);

        step("br_l3",      0, 2'b00, 1, 3'd3, 0, 6'h00, 6'h06, 1, 0, 0);
        step("br_defer",   0, 2'b10, 1, 3'd3, 0, 6'h0f, 6'h00, 0, 0, 0);
        step("br_over_st", 0, 2'b01, 1, 3'd4, 0, 6'h00, 6'h0e, 1, 0, 0);
        step("br_l1",      0, 2'b00, 1, 3'd1, 0, 6'h00, 6'h00, 1, 0, 0);
        step("br_l0",      0, 2'b00, 1, 3'd0, 0, 6'h00, 6'h00, 1, 0, 0);
        step("br_l7",      0, 2'b11, 1, 3'd7, 0, 6'h00, 6'h3e, 1, 0, 0);
        step("br_l0_st",   0, 2'b01, 1, 3'd0, 0, 6'h07, 6'h00, 0, 0, 0);
        step("idle1",      0, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 0);

        step("ex_run",   0, 2'b00, 0, 3'd0, 1, 6'h00, 6'h00, 0, 0, 0);
        step("ex_flush", 0, 2'b00, 0, 3'd0, 1, 6'h00, 6'h3f, 0, 1, 0);
        step("ex_dr1",   0, 2'b00, 0, 3'd0, 1, 6'h01, 6'h00, 0, 1, 0);
        step("ex_dr2",   0, 2'b00, 0, 3'd0, 1, 6'h01, 6'h00, 0, 1, 0);
        step("ex_ack",   0, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 1);
        step("ex_idle",  0, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 0);

        step("pr_run",   0, 2'b11, 1, 3'd3, 1, 6'h0f, 6'h00, 0, 0, 0);
        step("pr_flush", 0, 2'b11, 1, 3'd3, 1, 6'h00, 6'h3f, 0, 1, 0);
        step("pr_dr1",   0, 2'b11, 1, 3'd3, 1, 6'h01, 6'h00, 0, 1, 0);
        step("pr_dr2",   0, 2'b11, 1, 3'd7, 1, 6'h01, 6'h00, 0, 1, 0);
        step("pr_ack",   0, 2'b11, 0, 3'd0, 0, 6'h0f, 6'h00, 0, 0, 1);
        step("pr_idle",  0, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 0);

        // excp_req still high in the ack cycle restarts the sequence
        step("rt_run",   0, 2'b00, 0, 3'd0, 1, 6'h00, 6'h00, 0, 0, 0);
        step("rt_fl1",   0, 2'b00, 0, 3'd0, 1, 6'h00, 6'h3f, 0, 1, 0);
        step("rt_dr1",   0, 2'b00, 0, 3'd0, 1, 6'h01, 6'h00, 0, 1, 0);
        step("rt_dr2",   0, 2'b00, 0, 3'd0, 1, 6'h01, 6'h00, 0, 1, 0);
        step("rt_ack1",  0, 2'b00, 0, 3'd0, 1, 6'h00, 6'h00, 0, 0, 1);
        step("rt_fl2",   0, 2'b00, 0, 3'd0, 1, 6'h00, 6'h3f, 0, 1, 0);
        step("rt_dr3",   0, 2'b00, 0, 3'd0, 1, 6'h01, 6'h00, 0, 1, 0);
        step("rt_dr4",   0, 2'b00, 0, 3'd0, 1, 6'h01, 6'h00, 0, 1, 0);
        step("rt_ack2",  0, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 1);
        step("rt_idle",  0, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 0);

        step("ra_run",   0, 2'b00, 0, 3'd0, 1, 6'h00, 6'h00, 0, 0, 0);
        step("ra_flush", 0, 2'b00, 0, 3'd0, 1, 6'h00, 6'h3f, 0, 1, 0);
        step("ra_dr1",   0, 2'b00, 0, 3'd0, 1, 6'h01, 6'h00, 0, 1, 0);
        step("ra_rst",   1, 2'b00, 0, 3'd0, 1, 6'h00, 6'h00, 0, 0, 0);
        step("ra_post1", 0, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 0);
        step("ra_post2", 0, 2'b01, 0, 3'd0, 0, 6'h07, 6'h00, 0, 0, 0);
        step("ra_idle",  0, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 0);

        for (int k = 0; k < 6; k++)
            step($sformatf("wd_st%0d", k), 0, 2'b01, 0, 3'd0, 0,
                 6'h07, 6'h00, 0, 0, 0);
        step("wd_drop1", 0, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 0);
        step("wd_drop2", 0, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 0);
        step("wd_rst",   1, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 0);
        step("wd_clr",   0, 2'b00, 0, 3'd0, 0, 6'h00, 6'h00, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
